// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: consumes the parity and stop bits that follow a data word, then
// reports the frame with per-frame error flags, sticky status and saturating counters.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_MAX   = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             PAR_EN,
    input  logic [1:0]                       PAR_MODE,
    input  logic [$clog2(STOP_MAX+1)-1:0]    STOP_NUM,
    input  logic                             data_done,
    input  logic [DATA_WIDTH-1:0]            P_DATA,
    input  logic                             sampled_bit,
    input  logic                             sampling_done,
    input  logic                             frame_abort,
    input  logic                             err_clr,
    output logic                             frame_valid,
    output logic [DATA_WIDTH-1:0]            frame_data,
    output logic                             par_err,
    output logic                             stp_err,
    output logic [2:0]                       sticky_err,
    output logic [CNT_WIDTH-1:0]             par_err_cnt,
    output logic [CNT_WIDTH-1:0]             stp_err_cnt
);

    localparam int SW = $clog2(STOP_MAX + 1);
    localparam logic [SW-1:0] STOP_MAX_L = SW'(STOP_MAX);

    typedef enum logic [1:0] {S_IDLE, S_PAR, S_STOP, S_REPORT} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    exp_par_q;
    logic [SW-1:0]           stop_cnt_q;
    logic                    perr_int, serr_int;
    logic                    exp_par_in;
    logic                    enter_report;
    logic [2:0]              sticky_d;
    logic [CNT_WIDTH-1:0]    pcnt_d, scnt_d;

    function automatic logic [SW-1:0] clamp_stop(input logic [SW-1:0] n);
        if (n == '0)
            return SW'(1);
        else if (n > STOP_MAX_L)
            return STOP_MAX_L;
        else
            return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        exp_par_in = 1'b0;
        case (PAR_MODE)
            2'b00:   exp_par_in = ^P_DATA;
            2'b01:   exp_par_in = ~^P_DATA;
            2'b10:   exp_par_in = 1'b1;
            default: exp_par_in = 1'b0;
        endcase
    end

    // A new word always restarts the frame; abort outranks a coincident sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (data_done) state_d = PAR_EN ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (data_done)          state_d = PAR_EN ? S_PAR : S_STOP;
                else if (frame_abort)   state_d = S_IDLE;
                else if (sampling_done) state_d = S_STOP;
            end
            S_STOP: begin
                if (data_done)          state_d = PAR_EN ? S_PAR : S_STOP;
                else if (frame_abort)   state_d = S_IDLE;
                else if (sampling_done && stop_cnt_q == SW'(1)) state_d = S_REPORT;
            end
            S_REPORT: begin
                state_d = data_done ? (PAR_EN ? S_PAR : S_STOP) : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_report = (state_d == S_REPORT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            exp_par_q  <= 1'b0;
            stop_cnt_q <= '0;
            perr_int   <= 1'b0;
            serr_int   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (data_done) begin
                data_q     <= P_DATA;
                exp_par_q  <= exp_par_in;
                stop_cnt_q <= clamp_stop(STOP_NUM);
                perr_int   <= 1'b0;
                serr_int   <= 1'b0;
            end else if (sampling_done && !frame_abort) begin
                if (state_q == S_PAR) begin
                    perr_int <= (sampled_bit != exp_par_q);
                end else if (state_q == S_STOP) begin
                    serr_int   <= serr_int | ~sampled_bit;
                    stop_cnt_q <= stop_cnt_q - SW'(1);
                end
            end
        end
    end

    // Report register: loaded on the last stop sample, so it already folds in that bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            frame_valid <= enter_report;
            if (enter_report) begin
                frame_data <= data_q;
                par_err    <= perr_int;
                stp_err    <= serr_int | ~sampled_bit;
            end
        end
    end

    // Clear is applied before any same-cycle event so that event is never lost.
    always_comb begin
        sticky_d = err_clr ? 3'b000 : sticky_err;
        pcnt_d   = err_clr ? '0 : par_err_cnt;
        scnt_d   = err_clr ? '0 : stp_err_cnt;
        if (state_q == S_REPORT) begin
            if (par_err) begin
                sticky_d[0] = 1'b1;
                pcnt_d      = sat_inc(pcnt_d);
            end
            if (stp_err) begin
                sticky_d[1] = 1'b1;
                scnt_d      = sat_inc(scnt_d);
            end
        end
        if (data_done && (state_q == S_PAR || state_q == S_STOP))
            sticky_d[2] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sticky_err  <= 3'b000;
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            sticky_err  <= sticky_d;
            par_err_cnt <= pcnt_d;
            stp_err_cnt <= scnt_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (2-bit counters so saturation is reachable).
module tb_uart_rx_frame_check;

    localparam int DW = 8;
    localparam int SM = 2;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          PAR_EN = 1'b0;
    logic [1:0]    PAR_MODE = 2'b00;
    logic [1:0]    STOP_NUM = 2'd1;
    logic          data_done = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          sampled_bit = 1'b0;
    logic          sampling_done = 1'b0;
    logic          frame_abort = 1'b0;
    logic          err_clr = 1'b0;
    logic          frame_valid;
    logic [DW-1:0] frame_data;
    logic          par_err;
    logic          stp_err;
    logic [2:0]    sticky_err;
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stp_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_frame_check #(.DATA_WIDTH(DW), .STOP_MAX(SM), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .STOP_NUM(STOP_NUM),
        .data_done(data_done), .P_DATA(P_DATA), .sampled_bit(sampled_bit),
        .sampling_done(sampling_done), .frame_abort(frame_abort), .err_clr(err_clr),
        .frame_valid(frame_valid), .frame_data(frame_data), .par_err(par_err),
        .stp_err(stp_err), .sticky_err(sticky_err), .par_err_cnt(par_err_cnt),
        .stp_err_cnt(stp_err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic pen, input logic [1:0] mode,
                             input logic [1:0] stops);
        P_DATA = d; PAR_EN = pen; PAR_MODE = mode; STOP_NUM = stops;
        data_done = 1'b1;
        tick();
        data_done = 1'b0;
    endtask

    task automatic sample(input logic b);
        sampled_bit = b; sampling_done = 1'b1;
        tick();
        sampling_done = 1'b0;
    endtask

    initial begin
        tick();
        chk("rst_fv", frame_valid, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_sticky", sticky_err, 0);
        chk("rst_pcnt", par_err_cnt, 0);
        chk("rst_scnt", stp_err_cnt, 0);
        RST = 1'b1;
        tick();

        // Even parity, A5 has four ones -> parity bit 0
        send_word(8'hA5, 1'b1, 2'b00, 2'd1);
        sample(1'b0);
        chk("even_early_fv", frame_valid, 0);
        sample(1'b1);
        chk("even_fv", frame_valid, 1);
        chk("even_data", frame_data, 8'hA5);
        chk("even_perr", par_err, 0);
        chk("even_serr", stp_err, 0);
        tick();
        chk("even_fv_drop", frame_valid, 0);
        chk("even_pcnt", par_err_cnt, 0);
        chk("even_scnt", stp_err_cnt, 0);

        // Odd parity on 03 expects 1; receive 0
        send_word(8'h03, 1'b1, 2'b01, 2'd1);
        sample(1'b0);
        sample(1'b1);
        chk("odd_fv", frame_valid, 1);
        chk("odd_perr", par_err, 1);
        tick();
        chk("odd_sticky", sticky_err, 3'b001);
        chk("odd_pcnt", par_err_cnt, 1);

        send_word(8'h00, 1'b1, 2'b10, 2'd1);
        sample(1'b0);
        sample(1'b1);
        chk("mark_perr", par_err, 1);
        tick();
        chk("mark_pcnt", par_err_cnt, 2);

        send_word(8'hFF, 1'b1, 2'b11, 2'd1);
        sample(1'b0);
        sample(1'b1);
        chk("space_fv", frame_valid, 1);
        chk("space_perr", par_err, 0);
        tick();
        chk("space_pcnt", par_err_cnt, 2);

        // Two stop bits, second bad
        send_word(8'h5A, 1'b0, 2'b00, 2'd2);
        sample(1'b1);
        chk("stop2_mid_fv", frame_valid, 0);
        sample(1'b0);
        chk("stop2_fv", frame_valid, 1);
        chk("stop2_serr", stp_err, 1);
        chk("stop2_perr", par_err, 0);
        chk("stop2_data", frame_data, 8'h5A);
        tick();
        chk("stop2_scnt", stp_err_cnt, 1);
        chk("stop2_sticky", sticky_err, 3'b011);
        sample(1'b1);
        chk("idle_sample_fv", frame_valid, 0);
        tick();
        chk("idle_sample_fv2", frame_valid, 0);

        // Overrun: second word before the stop bit
        send_word(8'h11, 1'b0, 2'b00, 2'd1);
        send_word(8'h22, 1'b0, 2'b00, 2'd1);
        chk("ovr_sticky", sticky_err, 3'b111);
        sample(1'b1);
        chk("ovr_fv", frame_valid, 1);
        chk("ovr_data", frame_data, 8'h22);
        chk("ovr_serr", stp_err, 0);
        tick();
        sample(1'b1);
        chk("ovr_single_fv", frame_valid, 0);

        // Abort in STOP
        send_word(8'h33, 1'b0, 2'b00, 2'd2);
        sample(1'b1);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        sample(1'b1);
        chk("abort_fv", frame_valid, 0);
        tick();
        chk("abort_fv2", frame_valid, 0);
        chk("abort_hold_data", frame_data, 8'h22);
        chk("abort_scnt", stp_err_cnt, 1);

        // Clear, then saturate the parity counter
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_sticky", sticky_err, 0);
        chk("clr_pcnt", par_err_cnt, 0);
        chk("clr_scnt", stp_err_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            send_word(8'h01, 1'b1, 2'b10, 2'd1);
            sample(1'b0);
            sample(1'b1);
            tick();
        end
        chk("sat_pcnt", par_err_cnt, 3);
        send_word(8'h01, 1'b1, 2'b10, 2'd1);
        sample(1'b0);
        sample(1'b1);
        chk("clr_evt_fv", frame_valid, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_evt_pcnt", par_err_cnt, 1);
        chk("clr_evt_sticky", sticky_err, 3'b001);

        // Async reset during STOP
        send_word(8'h44, 1'b1, 2'b00, 2'd2);
        sample(1'b0);
        sample(1'b1);
        #2 RST = 1'b0;
        #1;
        chk("mrst_fv", frame_valid, 0);
        chk("mrst_data", frame_data, 0);
        chk("mrst_perr", par_err, 0);
        chk("mrst_sticky", sticky_err, 0);
        chk("mrst_pcnt", par_err_cnt, 0);
        RST = 1'b1;
        tick();
        sample(1'b1);
        chk("mrst_no_report", frame_valid, 0);
        send_word(8'hC3, 1'b1, 2'b00, 2'd1);
        sample(1'b0);
        sample(1'b1);
        chk("post_rst_fv", frame_valid, 1);
        chk("post_rst_data", frame_data, 8'hC3);
        chk("post_rst_perr", par_err, 0);
        tick();

        // Config changes after the snapshot must not matter
        send_word(8'h03, 1'b1, 2'b00, 2'd1);
        PAR_MODE = 2'b01;
        STOP_NUM = 2'd2;
        sample(1'b0);
        sample(1'b1);
        chk("snap_fv", frame_valid, 1);
        chk("snap_perr", par_err, 0);
        tick();

        // STOP_NUM 0 acts as 1, 3 clamps to 2
        send_word(8'h10, 1'b0, 2'b00, 2'd0);
        sample(1'b1);
        chk("stop0_fv", frame_valid, 1);
        tick();
        send_word(8'h20, 1'b0, 2'b00, 2'd3);
        sample(1'b1);
        chk("stop3_mid_fv", frame_valid, 0);
        sample(1'b1);
        chk("stop3_fv", frame_valid, 1);
        chk("stop3_data", frame_data, 8'h20);

        // New word during REPORT: report completes, no overrun
        send_word(8'h77, 1'b0, 2'b00, 2'd1);
        chk("rep_dd_fv_drop", frame_valid, 0);
        chk("rep_dd_hold", frame_data, 8'h20);
        sample(1'b1);
        chk("rep_dd_fv", frame_valid, 1);
        chk("rep_dd_data", frame_data, 8'h77);
        tick();
        chk("rep_dd_sticky", sticky_err, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
